// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception sequencer: register indices,
// ExcCode values, Status/Cause bit positions and FSM state encodings.
package cp0_exc_ctrl_pkg;

  // CP0 register indices
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_IBE  = 5'd6;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status / Cause bit positions
  localparam int unsigned STATUS_IEC = 0;
  localparam int unsigned STATUS_KUC = 1;
  localparam int unsigned STATUS_BEV = 22;
  localparam int unsigned CAUSE_BD   = 31;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_SAVE  = 2'd2;
  localparam logic [1:0] ST_REDIR = 2'd3;

  // Only address-error exceptions report a faulting address
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// Multi-flop synchronizer bringing the asynchronous hardware interrupt
// lines into the core clock domain.
module cp0_int_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [5:0] int_i,
  output logic [5:0] int_o
);

  logic [5:0] stage_q [DEPTH];

  // Shift chain of DEPTH flops, cleared by reset
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= int_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign int_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates exceptions against
// interrupts, runs flush -> save -> redirect, and serves MTC0/MFC0/RFE.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0080,
  parameter logic [31:0] BEV_VECTOR = 32'hBFC0_0180,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0100,
  parameter int unsigned INT_SYNC   = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badva,
  input  logic [5:0]  int_hw,
  input  logic        rfe,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        stall,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ack,
  output logic        status_kuc,
  output logic        status_iec
);

  if (INT_SYNC < 2) begin : g_bad_sync
    $error("cp0_exc_ctrl: INT_SYNC must be at least 2");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic        cause_bd_q, cause_bd_d;
  logic [4:0]  cause_code_q, cause_code_d;
  logic [1:0]  cause_sw_q, cause_sw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badva_q, badva_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [4:0]  trig_code_q, trig_code_d;
  logic [31:0] trig_pc_q, trig_pc_d;
  logic        trig_bd_q, trig_bd_d;
  logic [31:0] trig_badva_q, trig_badva_d;

  logic [5:0]  ip_hw;
  logic [31:0] cause_rd;
  logic        int_pend;
  logic        trigger;

  cp0_int_sync #(
    .DEPTH (INT_SYNC)
  ) u_int_sync (
    .clk_i  (clk),
    .nrst_i (nrst),
    .int_i  (int_hw),
    .int_o  (ip_hw)
  );

  assign cause_rd = {cause_bd_q, 15'b0, ip_hw, cause_sw_q, 1'b0, cause_code_q, 2'b00};
  assign int_pend = status_q[STATUS_IEC] & (|(cause_rd[15:8] & status_q[15:8]));
  assign trigger  = exc_valid | int_pend;

  // Next-state: trigger capture in IDLE, register update in SAVE,
  // RFE/MTC0 only in IDLE when no trigger claims the cycle
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    cause_bd_d   = cause_bd_q;
    cause_code_d = cause_code_q;
    cause_sw_d   = cause_sw_q;
    epc_d        = epc_q;
    badva_d      = badva_q;
    redir_pc_d   = redir_pc_q;
    trig_code_d  = trig_code_q;
    trig_pc_d    = trig_pc_q;
    trig_bd_d    = trig_bd_q;
    trig_badva_d = trig_badva_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d      = ST_FLUSH;
          trig_code_d  = exc_valid ? exc_code : EXC_INT;
          trig_pc_d    = exc_pc;
          trig_bd_d    = exc_bd;
          trig_badva_d = exc_badva;
        end else begin
          if (rfe) status_d[5:0] = {status_q[5:4], status_q[5:2]};
          if (cp0_wen) begin
            case (cp0_addr)
              CP0_STATUS: status_d   = cp0_wdata;
              CP0_CAUSE:  cause_sw_d = cp0_wdata[9:8];
              CP0_EPC:    epc_d      = cp0_wdata;
              default:    ;
            endcase
          end
        end
      end
      ST_FLUSH: state_d = ST_SAVE;
      ST_SAVE: begin
        state_d      = ST_REDIR;
        epc_d        = trig_bd_q ? (trig_pc_q - 32'd4) : trig_pc_q;
        cause_bd_d   = trig_bd_q;
        cause_code_d = trig_code_q;
        if (is_addr_exc(trig_code_q)) badva_d = trig_badva_q;
        status_d[5:0] = {status_q[3:0], 2'b00};
        redir_pc_d   = status_q[STATUS_BEV] ? BEV_VECTOR : EXC_VECTOR;
      end
      ST_REDIR: if (redir_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      status_q     <= 32'h0040_0000;
      cause_bd_q   <= 1'b0;
      cause_code_q <= '0;
      cause_sw_q   <= '0;
      epc_q        <= '0;
      badva_q      <= '0;
      redir_pc_q   <= '0;
      trig_code_q  <= '0;
      trig_pc_q    <= '0;
      trig_bd_q    <= 1'b0;
      trig_badva_q <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      cause_bd_q   <= cause_bd_d;
      cause_code_q <= cause_code_d;
      cause_sw_q   <= cause_sw_d;
      epc_q        <= epc_d;
      badva_q      <= badva_d;
      redir_pc_q   <= redir_pc_d;
      trig_code_q  <= trig_code_d;
      trig_pc_q    <= trig_pc_d;
      trig_bd_q    <= trig_bd_d;
      trig_badva_q <= trig_badva_d;
    end
  end

  // MFC0 read mux; unimplemented indices read as zero
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badva_q;
      CP0_STATUS:   cp0_rdata = status_q;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = epc_q;
      CP0_PRID:     cp0_rdata = PRID_VALUE;
      default:      cp0_rdata = '0;
    endcase
  end

  assign stall       = (state_q != ST_IDLE);
  assign flush       = (state_q == ST_FLUSH);
  assign redir_valid = (state_q == ST_REDIR);
  assign redir_pc    = redir_pc_q;
  assign status_kuc  = status_q[STATUS_KUC];
  assign status_iec  = status_q[STATUS_IEC];

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized self-checking bench for cp0_exc_ctrl against a register-level
// reference model of the CP0 architectural state.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h8000_0080;
  localparam logic [31:0] BEV_VEC = 32'hBFC0_0180;
  localparam logic [31:0] PRID    = 32'h0000_0100;
  localparam int unsigned SYNC    = 2;

  logic        clk, nrst;
  logic        exc_valid, exc_bd, rfe, cp0_wen, redir_ack;
  logic [4:0]  exc_code, cp0_addr;
  logic [31:0] exc_pc, exc_badva, cp0_wdata;
  logic [5:0]  int_hw;
  logic [31:0] cp0_rdata, redir_pc;
  logic        stall, flush, redir_valid, status_kuc, status_iec;

  int errors = 0;
  int checks = 0;

  // Reference model of architectural state
  logic [31:0] m_status, m_epc, m_badva;
  logic        m_bd;
  logic [4:0]  m_code;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;

  cp0_exc_ctrl #(
    .EXC_VECTOR (EXC_VEC),
    .BEV_VECTOR (BEV_VEC),
    .PRID_VALUE (PRID),
    .INT_SYNC   (SYNC)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .exc_badva   (exc_badva),
    .int_hw      (int_hw),
    .rfe         (rfe),
    .cp0_wen     (cp0_wen),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .stall       (stall),
    .flush       (flush),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ack   (redir_ack),
    .status_kuc  (status_kuc),
    .status_iec  (status_iec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badva;
      5'd12:   return m_status;
      5'd13:   return {m_bd, 15'b0, m_hw, m_sw, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_reset();
    m_status = 32'h0040_0000;
    m_epc = 0; m_badva = 0; m_bd = 0; m_code = 0; m_sw = 0; m_hw = 0;
  endfunction

  function automatic logic [31:0] m_vector();
    return m_status[22] ? BEV_VEC : EXC_VEC;
  endfunction

  function automatic void m_take(input logic [4:0] code, input logic [31:0] pc,
                                 input logic bd, input logic [31:0] badva);
    m_epc  = bd ? pc - 32'd4 : pc;
    m_bd   = bd;
    m_code = code;
    if (code == 5'd4 || code == 5'd5) m_badva = badva;
    m_status[5:0] = {m_status[3:0], 2'b00};
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cp0_wen = 1; cp0_addr = a; cp0_wdata = d;
    @(posedge clk); #1;
    cp0_wen = 0;
    case (a)
      5'd12: m_status = d;
      5'd13: m_sw = d[9:8];
      5'd14: m_epc = d;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_addr = a; #1; v = cp0_rdata;
  endtask

  // Drives one trigger cycle (cycle 0) and follows the sequence, reporting
  // the cycle numbers at which flush, redirect and return to idle are seen.
  task automatic fire(input logic v, input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic [31:0] badva,
                      input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input int ack_after,
                      output int flush_at, output int flush_n, output int redir_at,
                      output int idle_at, output logic [31:0] pc_seen);
    int rcount;
    @(posedge clk); #1;
    exc_valid = v; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badva = badva;
    rfe = r; cp0_wen = w; cp0_addr = wa; cp0_wdata = wd;
    flush_at = -1; flush_n = 0; redir_at = -1; idle_at = -1; pc_seen = 0; rcount = 0;
    for (int c = 1; c <= 40 && idle_at < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin exc_valid = 0; rfe = 0; cp0_wen = 0; end
      redir_ack = 0;
      @(negedge clk);
      if (flush) begin flush_n++; if (flush_at < 0) flush_at = c; end
      if (redir_valid) begin
        if (redir_at < 0) begin redir_at = c; pc_seen = redir_pc; end
        if (rcount == ack_after) redir_ack = 1;
        rcount++;
      end else if (!stall && redir_at >= 0) idle_at = c;
    end
    redir_ack = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    nrst = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badva = 0;
    int_hw = 0; rfe = 0; cp0_wen = 0; cp0_addr = 0; cp0_wdata = 0; redir_ack = 0;
    m_reset();
    wait_cycles(3);
    checks++; if ({stall, flush, redir_valid} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl: got %b exp 000", {stall, flush, redir_valid}); end
    checks++; if (redir_pc !== 32'h0) begin errors++;
      $display("FAIL reset_redir_pc: got %h exp 0", redir_pc); end
    for (int i = 0; i < 5; i++) begin
      logic [4:0] a;
      a = (i == 4) ? 5'd8 : 5'(12 + i);
      rd(a, v);
      checks++; if (v !== m_read(a)) begin errors++;
        $display("FAIL reset_reg%0d: got %h exp %h", a, v, m_read(a)); end
    end
    @(negedge clk); nrst = 1;
    wait_cycles(2);
  endtask

  task automatic test_syscall();
    int fa, fn, ra, ia; logic [31:0] ps, v;
    mtc0(5'd12, 32'h0040_0003);
    fire(1, 5'd8, 32'h0000_1000, 0, 32'h0, 0, 0, 0, 0, 0, fa, fn, ra, ia, ps);
    m_take(5'd8, 32'h0000_1000, 0, 32'h0);
    checks++; if (fa !== 1 || fn !== 1) begin errors++;
      $display("FAIL sys_flush: got at=%0d n=%0d exp at=1 n=1", fa, fn); end
    checks++; if (ra !== 3 || ia !== 4) begin errors++;
      $display("FAIL sys_timing: got redir=%0d idle=%0d exp 3/4", ra, ia); end
    checks++; if (ps !== BEV_VEC) begin errors++;
      $display("FAIL sys_vector: got %h exp %h", ps, BEV_VEC); end
    for (int a = 12; a <= 14; a++) begin
      rd(5'(a), v);
      checks++; if (v !== m_read(5'(a))) begin errors++;
        $display("FAIL sys_reg%0d: got %h exp %h", a, v, m_read(5'(a))); end
    end
  endtask

  task automatic test_bd_adel();
    int fa, fn, ra, ia; logic [31:0] ps, v;
    fire(1, 5'd4, 32'h0000_0000, 1, 32'h0000_0003, 0, 0, 0, 0, 0, fa, fn, ra, ia, ps);
    m_take(5'd4, 32'h0, 1, 32'h3);
    rd(5'd14, v);
    checks++; if (v !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL bd_epc: got %h exp FFFFFFFC", v); end
    rd(5'd13, v);
    checks++; if (v !== m_read(5'd13)) begin errors++;
      $display("FAIL bd_cause: got %h exp %h", v, m_read(5'd13)); end
    rd(5'd8, v);
    checks++; if (v !== 32'h3) begin errors++;
      $display("FAIL bd_badva: got %h exp 00000003", v); end
  endtask

  task automatic test_interrupt();
    int nstall, fa, ia, rc; logic [31:0] v;
    mtc0(5'd12, 32'h0040_0400);
    int_hw = 6'b000001;
    nstall = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (stall) nstall++; end
    checks++; if (nstall !== 0) begin errors++;
      $display("FAIL int_masked: got %0d stall cycles exp 0", nstall); end
    @(posedge clk); #1; int_hw = 0;
    wait_cycles(4);
    mtc0(5'd12, 32'h0040_0401);
    @(posedge clk); #1;
    int_hw = 6'b000001; exc_pc = 32'h0000_2468; exc_bd = 0; exc_valid = 0;
    fa = -1; ia = -1; rc = 0;
    for (int c = 1; c <= 30 && ia < 0; c++) begin
      @(posedge clk); #1; redir_ack = 0;
      @(negedge clk);
      if (flush && fa < 0) fa = c;
      if (redir_valid) begin redir_ack = 1; rc++; end
      else if (!stall && rc > 0) ia = c;
    end
    redir_ack = 0;
    m_hw = 6'b000001;
    m_take(5'd0, 32'h0000_2468, 0, 32'h0);
    checks++; if (fa !== SYNC + 1) begin errors++;
      $display("FAIL int_latency: got flush at %0d exp %0d", fa, SYNC + 1); end
    rd(5'd13, v);
    checks++; if (v !== m_read(5'd13)) begin errors++;
      $display("FAIL int_cause: got %h exp %h", v, m_read(5'd13)); end
    rd(5'd14, v);
    checks++; if (v !== m_epc) begin errors++;
      $display("FAIL int_epc: got %h exp %h", v, m_epc); end
    rd(5'd12, v);
    checks++; if (v !== m_status) begin errors++;
      $display("FAIL int_status: got %h exp %h", v, m_status); end
    int_hw = 0;
    wait_cycles(4);
    m_hw = 0;
  endtask

  task automatic test_priority();
    int fa, fn, ra, ia; logic [31:0] ps, v;
    mtc0(5'd12, 32'h0040_0401);
    @(posedge clk); #1; int_hw = 6'b000001;
    @(posedge clk); #1;
    fire(1, 5'd12, 32'h0000_3000, 0, 32'h0, 1, 1, 5'd14, 32'hDEAD_BEEF, 5,
         fa, fn, ra, ia, ps);
    m_hw = 6'b000001;
    m_take(5'd12, 32'h0000_3000, 0, 32'h0);
    checks++; if (fa !== 1 || ra !== 3) begin errors++;
      $display("FAIL prio_timing: got flush=%0d redir=%0d exp 1/3", fa, ra); end
    checks++; if (ia !== 9) begin errors++;
      $display("FAIL prio_hold: got idle at %0d exp 9", ia); end
    for (int a = 12; a <= 14; a++) begin
      rd(5'(a), v);
      checks++; if (v !== m_read(5'(a))) begin errors++;
        $display("FAIL prio_reg%0d: got %h exp %h", a, v, m_read(5'(a))); end
    end
    int_hw = 0;
    wait_cycles(4);
    m_hw = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    mtc0(5'd12, 32'h0040_0003);
    @(posedge clk); #1;
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h0000_5000; exc_bd = 0;
    @(posedge clk); #1; exc_valid = 0;
    wait_cycles(2);
    @(negedge clk);
    checks++; if (redir_valid !== 1'b1) begin errors++;
      $display("FAIL mid_redir_before: got %b exp 1", redir_valid); end
    nrst = 0; #1;
    checks++; if ({redir_valid, stall} !== 2'b00) begin errors++;
      $display("FAIL mid_reset_drop: got %b exp 00", {redir_valid, stall}); end
    m_reset();
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;
    rd(5'd12, v);
    checks++; if (v !== m_status) begin errors++;
      $display("FAIL mid_status: got %h exp %h", v, m_status); end
    rd(5'd14, v);
    checks++; if (v !== m_epc) begin errors++;
      $display("FAIL mid_epc: got %h exp %h", v, m_epc); end
    mtc0(5'd12, 32'h0040_002C);
    @(posedge clk); #1; rfe = 1;
    @(posedge clk); #1; rfe = 0;
    m_status[5:0] = {m_status[5:4], m_status[5:2]};
    rd(5'd12, v);
    checks++; if (v !== 32'h0040_002B || v !== m_status) begin errors++;
      $display("FAIL rfe_status: got %h exp %h", v, m_status); end
  endtask

  task automatic test_random();
    int fa, fn, ra, ia, ack; logic [31:0] ps, v, vec, pc, bva, st;
    logic [4:0] code, a; logic bd;
    for (int it = 0; it < 24; it++) begin
      st = $urandom & 32'hFFFF_00FF;
      mtc0(5'd12, st);
      mtc0(5'd13, $urandom);
      if ($urandom_range(0, 1) == 1) mtc0(5'd14, $urandom);
      case ($urandom_range(0, 3))
        0: a = 5'd8;
        1: a = 5'd15;
        2: a = 5'(2 * $urandom_range(0, 3) + 1);
        default: a = 5'(16 + $urandom_range(0, 15));
      endcase
      mtc0(a, $urandom);
      a = 5'($urandom_range(0, 31));
      rd(a, v);
      checks++; if (v !== m_read(a)) begin errors++;
        $display("FAIL rnd_read%0d_it%0d: got %h exp %h", a, it, v, m_read(a)); end
      code = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(1, 31));
      pc = $urandom; bd = 1'($urandom_range(0, 1)); bva = $urandom;
      ack = $urandom_range(0, 3);
      vec = m_vector();
      fire(1, code, pc, bd, bva, 0, 0, 0, 0, ack, fa, fn, ra, ia, ps);
      m_take(code, pc, bd, bva);
      checks++; if (fa !== 1 || fn !== 1 || ra !== 3 || ia !== 4 + ack) begin errors++;
        $display("FAIL rnd_timing_it%0d: got f=%0d n=%0d r=%0d i=%0d exp 1/1/3/%0d",
                 it, fa, fn, ra, ia, 4 + ack); end
      checks++; if (ps !== vec) begin errors++;
        $display("FAIL rnd_vector_it%0d: got %h exp %h", it, ps, vec); end
      for (int k = 0; k < 4; k++) begin
        a = (k == 0) ? 5'd8 : 5'(11 + k);
        rd(a, v);
        checks++; if (v !== m_read(a)) begin errors++;
          $display("FAIL rnd_reg%0d_it%0d: got %h exp %h", a, it, v, m_read(a)); end
      end
      checks++; if ({status_kuc, status_iec} !== m_status[1:0]) begin errors++;
        $display("FAIL rnd_kuie_it%0d: got %b exp %b", it, {status_kuc, status_iec}, m_status[1:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_bd_adel();
    test_interrupt();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
